// File: rtl/regfl_mp.sv
// regfl_mp: multi-port flop-based register file with byte-masked write,
// two registered read ports with write bypass, bulk clear and valid bits.
module regfl_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH/8-1:0]     wbe,
  input  logic [WIDTH-1:0]       wd,
  input  logic [AW-1:0]          ra,
  input  logic [AW-1:0]          rb,
  output logic [WIDTH-1:0]       qa,
  output logic [WIDTH-1:0]       qb,
  output logic [DEPTH-1:0]       vld,
  output logic [WIDTH*DEPTH-1:0] q
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [WIDTH-1:0] wmerge;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;
  logic             wr_en;

  // entry 0 is read-only when hardwired to zero; empty masks do nothing
  assign wr_en = we && (|wbe) && !(ZERO_REG && (wa == '0));

  // new bytes over the old contents of the addressed entry
  always_comb begin
    wmerge = mem[wa];
    for (int k = 0; k < NB; k++) begin
      if (wbe[k]) begin
        wmerge[8*k +: 8] = wd[8*k +: 8];
      end
    end
  end

  // read selection: storage, write-through bypass, forced-zero entry
  always_comb begin
    rda = mem[ra];
    rdb = mem[rb];
    if (wr_en && (wa == ra)) begin
      rda = wmerge;
    end
    if (wr_en && (wa == rb)) begin
      rdb = wmerge;
    end
    if (ZERO_REG && (ra == '0)) begin
      rda = '0;
    end
    if (ZERO_REG && (rb == '0)) begin
      rdb = '0;
    end
  end

  // storage, valid bits and read registers; rst > clr > write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      vld_r <= '0;
      qa    <= '0;
      qb    <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      vld_r <= '0;
      qa    <= '0;
      qb    <= '0;
    end else begin
      if (wr_en) begin
        mem[wa]   <= wmerge;
        vld_r[wa] <= 1'b1;
      end
      qa <= rda;
      qb <= rdb;
    end
  end

  assign vld = vld_r;

  for (genvar i = 0; i < DEPTH; i++) begin : g_q
    assign q[WIDTH*DEPTH-1-i*WIDTH -: WIDTH] =
      (ZERO_REG && (i == 0)) ? '0 : mem[i];
  end

endmodule

// File: doc/regfl_mp.md
Name: regfl_mp

Overview:
- Parametrised multi-port register file. Successor to the 8x64 single-write register file; generalised in width and depth.
- Provides:
  - one byte-masked write port
  - two registered read ports with write-to-read bypass
  - synchronous bulk clear
  - per-entry valid bits
  - optional hardwired-zero entry 0
- Keeps the flattened all-entries output bus for debug and parallel consumers. Sits between the datapath write-back stage and operand fetch.

Parameters:
- WIDTH, 64, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; power of 2, at least 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- ZERO_REG, 0, if 1: entry 0 always reads 0, writes to it are ignored, and its valid bit stays 0.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- clr, in, 1, synchronous clear of all entries and valid bits.
- we, in, 1, write enable.
- wa, in, AW, write address.
- wbe, in, WIDTH/8, byte enables; bit k covers wd[8k+7:8k].
- wd, in, WIDTH, write data.
- ra, in, AW, read port A address.
- rb, in, AW, read port B address.
- qa, out, WIDTH, read port A data (registered).
- qb, out, WIDTH, read port B data (registered).
- vld, out, DEPTH, per-entry valid bits.
- q, out, WIDTH*DEPTH, all entries flattened; entry i at q[WIDTH*DEPTH-1-i*WIDTH -: WIDTH], so entry 0 occupies the MSBs.

Behaviour:
- Reset:
  - rst high forces all entries, qa, qb and vld to 0 immediately, independent of clk.
  - While rst is high, no writes occur.
  - On deassertion, the first rising edge operates normally.
- Priority on each rising edge: rst > clr > we.
- Clear (clr=1):
  - All entries and all vld bits go to 0 at the edge.
  - A simultaneous we is ignored.
  - qa and qb load 0.
- Write (we=1, clr=0):
  - For each k with wbe[k]=1, byte k of entry[wa] takes wd byte k. Other bytes are unchanged.
  - vld[wa] is set to 1 if any wbe bit is 1.
  - we=1 with wbe=0 is a no-op: entry and vld unchanged.
  - If ZERO_REG=1 and wa=0, the write is dropped.
- Read latency is 1 cycle:
  - At each edge, qa loads the value of entry[ra] that is visible after this edge's write. Same for qb with rb.
  - Bypass: if we=1 and wa==ra in the same cycle, qa gets the byte-merged value (new bytes where wbe=1, old bytes elsewhere). Same rule for qb and rb.
  - Both ports may address the same entry; both return identical data.
  - If ZERO_REG=1, a read of address 0 always returns 0.
- q and vld:
  - Driven directly from the storage registers, so they reflect writes in the cycle after the edge with no extra latency beyond storage.
  - With ZERO_REG=1, the entry-0 slice of q is constant 0.
- Addresses: DEPTH is a power of 2, so every address is in range and there are no out-of-range cases.
- Reset mid-operation: an asserted rst overrides any in-flight write or clear in that cycle; nothing partial is retained.
- Storage implemented as flip-flops (not inferred RAM), since all entries are exposed on q.

Test Plan (WIDTH=64, DEPTH=8, ZERO_REG=0 unless stated):
1. Reset then single write:
   - Stimulus: rst pulse 25 ns; then we=1, wa=1, wbe=8'hFF, wd=64'h1122334455667788 for one edge.
   - Required: q[447:384]=64'h1122334455667788, vld=8'b0000_0010, all other entries 0.
   - Required: asserting rst asynchronously mid-cycle zeroes q, qa, qb and vld before the next edge.
2. Byte-masked write:
   - Stimulus: entry 3 = 64'hFFFF_FFFF_FFFF_FFFF; then we=1, wa=3, wbe=8'h0F, wd=64'h0.
   - Required: entry 3 = 64'hFFFF_FFFF_0000_0000.
   - Stimulus: we=1, wa=4, wbe=8'h00.
   - Required: entry 4 and vld[4] unchanged.
3. Bypass on both ports:
   - Stimulus: entry 5 = 64'hAAAA_AAAA_AAAA_AAAA; then in one cycle ra=rb=5, we=1, wa=5, wbe=8'hF0, wd=64'h5555_5555_5555_5555.
   - Required: after that edge, qa = qb = 64'h5555_5555_AAAA_AAAA, and entry 5 holds the same value.
4. Clear beats write:
   - Stimulus: several entries written; then clr=1 and we=1, wa=2, wd=64'd7 in the same cycle.
   - Required: all entries 0, vld=0, qa=qb=0 after the edge.
   - Required: next cycle, a write to entry 2 with wd=64'd7 and wbe=8'hFF sets vld[2]=1.
5. ZERO_REG=1:
   - Stimulus: we=1, wa=0, wbe=8'hFF, wd=64'd9; ra=0.
   - Required: qa=0, q[511:448]=0, vld[0]=0.
   - Stimulus: write wd=64'd9 to entry 7.
   - Required: entry 7 reads 64'd9.
6. Parametrisation (WIDTH=16, DEPTH=16):
   - Stimulus: write each entry i with wd=16'h100+i and wbe=2'b11; then sweep ra and rb over all addresses.
   - Required: qa and qb show 16'h100+i one cycle after each address is applied.
   - Required: q slices are ordered with entry 0 at the MSBs, and vld=16'hFFFF.
